// File: rtl/bus_port_fifo.sv
// Bus port with a host-to-bus TX FIFO and an address-filtered bus-to-host RX FIFO.
// Both FIFOs are show-ahead and have saturating 8-bit drop counters.
module bus_port_fifo #(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16,
  parameter int depth   = 8,
  parameter int ID      = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [pckg_sz-1:0] wr_data,
  output logic               tx_full,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rd_data,
  input  logic               rd_en,
  output logic [7:0]         tx_ovf_cnt,
  output logic [7:0]         rx_drop_cnt
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [AW:0] full_cnt = (AW+1)'(depth);
  localparam logic [7:0]  my_id    = 8'(ID);

  if (depth < 2 || depth > 256 || (depth & (depth - 1)) != 0) begin : g_bad_depth
    $error("bus_port_fifo: depth must be a power of two in 2..256");
  end
  if (ID < 0 || ID >= drvrs) begin : g_bad_id
    $error("bus_port_fifo: ID must be in 0..drvrs-1");
  end
  if (pckg_sz < 8) begin : g_bad_width
    $error("bus_port_fifo: pckg_sz must hold an 8-bit destination");
  end

  // Handshake: pndng/rx_valid act as "valid" from registered state only;
  // pop/rd_en consume the show-ahead head and are ignored while not valid.
  logic [pckg_sz-1:0] tx_mem [0:depth-1];
  logic [AW-1:0]      tx_wr_ptr, tx_rd_ptr;
  logic [AW:0]        tx_count;
  logic               tx_do_wr, tx_do_pop, tx_ovf;

  logic [pckg_sz-1:0] rx_mem [0:depth-1];
  logic [AW-1:0]      rx_wr_ptr, rx_rd_ptr;
  logic [AW:0]        rx_count;
  logic               rx_accept, rx_do_wr, rx_do_rd, rx_drop;
  logic [7:0]         dest;

  assign pndng    = (tx_count != '0);
  assign tx_full  = (tx_count == full_cnt);
  assign rx_valid = (rx_count != '0);
  assign D_pop    = pndng    ? tx_mem[tx_rd_ptr] : '0;
  assign rd_data  = rx_valid ? rx_mem[rx_rd_ptr] : '0;

  // A full FIFO may still take a write when its head is consumed on the same edge.
  assign tx_do_pop = pop && pndng;
  assign tx_do_wr  = wr_en && (!tx_full || tx_do_pop);
  assign tx_ovf    = wr_en && tx_full && !pop;

  assign dest      = D_push[pckg_sz-1 -: 8];
  assign rx_accept = push && ((dest == my_id) || (dest == 8'hFF));
  assign rx_do_rd  = rd_en && rx_valid;
  assign rx_do_wr  = rx_accept && ((rx_count != full_cnt) || rx_do_rd);
  assign rx_drop   = rx_accept && (rx_count == full_cnt) && !rd_en;

  always_ff @(posedge clk) begin
    if (!reset && tx_do_wr) tx_mem[tx_wr_ptr] <= wr_data;
    if (!reset && rx_do_wr) rx_mem[rx_wr_ptr] <= D_push;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      tx_count    <= '0;
      tx_ovf_cnt  <= '0;
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      rx_drop_cnt <= '0;
    end else begin
      if (tx_do_wr)  tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_do_pop) tx_rd_ptr <= tx_rd_ptr + AW'(1);
      case ({tx_do_wr, tx_do_pop})
        2'b10:   tx_count <= tx_count + (AW+1)'(1);
        2'b01:   tx_count <= tx_count - (AW+1)'(1);
        default: tx_count <= tx_count;
      endcase
      if (tx_ovf && tx_ovf_cnt != 8'hFF) tx_ovf_cnt <= tx_ovf_cnt + 8'd1;

      if (rx_do_wr) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_do_rd) rx_rd_ptr <= rx_rd_ptr + AW'(1);
      case ({rx_do_wr, rx_do_rd})
        2'b10:   rx_count <= rx_count + (AW+1)'(1);
        2'b01:   rx_count <= rx_count - (AW+1)'(1);
        default: rx_count <= rx_count;
      endcase
      if (rx_drop && rx_drop_cnt != 8'hFF) rx_drop_cnt <= rx_drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_bus_port_fifo.sv
// Directed bench for bus_port_fifo (depth 8, 16-bit packets, port ID 2).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_bus_port_fifo;

  logic        clk = 1'b0;
  logic        reset, wr_en, pop, push, rd_en;
  logic [15:0] wr_data, D_push;
  logic        tx_full, pndng, rx_valid;
  logic [15:0] D_pop, rd_data;
  logic [7:0]  tx_ovf_cnt, rx_drop_cnt;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  bus_port_fifo #(.drvrs(4), .pckg_sz(16), .depth(8), .ID(2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
    .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rd_data(rd_data), .rd_en(rd_en),
    .tx_ovf_cnt(tx_ovf_cnt), .rx_drop_cnt(rx_drop_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; pop = 1'b0; push = 1'b0; rd_en = 1'b0;
    wr_data = '0; D_push = '0;
    step(); step();
    reset = 1'b0;
    checks++; if (pndng !== 1'b0) begin failures++; $display("FAIL rst_pndng got=%0h exp=0", pndng); end
    checks++; if (tx_full !== 1'b0) begin failures++; $display("FAIL rst_tx_full got=%0h exp=0", tx_full); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rst_rx_valid got=%0h exp=0", rx_valid); end
    checks++; if (D_pop !== 16'h0) begin failures++; $display("FAIL rst_D_pop got=%h exp=0000", D_pop); end
    checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL rst_rd_data got=%h exp=0000", rd_data); end
    checks++; if (tx_ovf_cnt !== 8'd0 || rx_drop_cnt !== 8'd0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", tx_ovf_cnt, rx_drop_cnt); end
  endtask

  task automatic test_tx_order();
    wr_en = 1'b1; wr_data = 16'h0102;
    step();
    checks++; if (pndng !== 1'b1 || D_pop !== 16'h0102) begin failures++; $display("FAIL tx_first_latency got=%0h/%h exp=1/0102", pndng, D_pop); end
    wr_data = 16'h0203; step();
    wr_data = 16'h0304; step();
    wr_en = 1'b0; pop = 1'b1;
    checks++; if (D_pop !== 16'h0102) begin failures++; $display("FAIL tx_pop0 got=%h exp=0102", D_pop); end
    step();
    checks++; if (D_pop !== 16'h0203) begin failures++; $display("FAIL tx_pop1 got=%h exp=0203", D_pop); end
    step();
    checks++; if (D_pop !== 16'h0304) begin failures++; $display("FAIL tx_pop2 got=%h exp=0304", D_pop); end
    step();
    checks++; if (pndng !== 1'b0 || D_pop !== 16'h0) begin failures++; $display("FAIL tx_drained got=%0h/%h exp=0/0000", pndng, D_pop); end
    step(); // pop on empty must be ignored
    pop = 1'b0; wr_en = 1'b1; wr_data = 16'h0405;
    step();
    wr_en = 1'b0;
    checks++; if (D_pop !== 16'h0405 || tx_ovf_cnt !== 8'd0) begin failures++; $display("FAIL tx_empty_pop_ignored got=%h/%0d exp=0405/0", D_pop, tx_ovf_cnt); end
    pop = 1'b1; step(); pop = 1'b0;
    checks++; if (pndng !== 1'b0) begin failures++; $display("FAIL tx_empty_again got=%0h exp=0", pndng); end
  endtask

  task automatic test_tx_overflow();
    for (int k = 0; k < 10; k++) begin
      wr_en = 1'b1; wr_data = 16'h0A00 + 16'(k);
      step();
      if (k == 6) begin checks++; if (tx_full !== 1'b0) begin failures++; $display("FAIL tx_full_at7 got=%0h exp=0", tx_full); end end
      if (k == 7) begin checks++; if (tx_full !== 1'b1) begin failures++; $display("FAIL tx_full_at8 got=%0h exp=1", tx_full); end end
    end
    checks++; if (tx_ovf_cnt !== 8'd2) begin failures++; $display("FAIL tx_ovf_two got=%0d exp=2", tx_ovf_cnt); end
    wr_data = 16'hBEEF; pop = 1'b1;
    step();
    wr_en = 1'b0; pop = 1'b0;
    checks++; if (tx_ovf_cnt !== 8'd2 || tx_full !== 1'b1 || D_pop !== 16'h0A01) begin failures++; $display("FAIL tx_full_wr_pop got=%0d/%0h/%h exp=2/1/0a01", tx_ovf_cnt, tx_full, D_pop); end
    pop = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      logic [15:0] exp_v;
      exp_v = (k < 8) ? 16'h0A00 + 16'(k) : 16'hBEEF;
      checks++; if (D_pop !== exp_v) begin failures++; $display("FAIL tx_drain_%0d got=%h exp=%h", k, D_pop, exp_v); end
      step();
    end
    pop = 1'b0;
    checks++; if (pndng !== 1'b0 || tx_full !== 1'b0) begin failures++; $display("FAIL tx_drain_end got=%0h/%0h exp=0/0", pndng, tx_full); end
    // write and pop together on an empty FIFO: only the write happens
    wr_en = 1'b1; pop = 1'b1; wr_data = 16'h1234;
    step();
    wr_en = 1'b0; pop = 1'b0;
    checks++; if (pndng !== 1'b1 || D_pop !== 16'h1234) begin failures++; $display("FAIL tx_empty_wr_pop got=%0h/%h exp=1/1234", pndng, D_pop); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; pop = 1'b1; wr_data = 16'h5000 + 16'(i);
      step();
      checks++; if (D_pop !== 16'h5000 + 16'(i) || tx_full !== 1'b0) begin failures++; $display("FAIL tx_wrap_%0d got=%h exp=%h", i, D_pop, 16'h5000 + 16'(i)); end
    end
    wr_en = 1'b0; pop = 1'b1;
    step();
    pop = 1'b0;
    checks++; if (pndng !== 1'b0 || tx_ovf_cnt !== 8'd2) begin failures++; $display("FAIL tx_wrap_end got=%0h/%0d exp=0/2", pndng, tx_ovf_cnt); end
  endtask

  task automatic test_rx_filter();
    push = 1'b1; D_push = 16'h0211;
    step();
    checks++; if (rx_valid !== 1'b1 || rd_data !== 16'h0211) begin failures++; $display("FAIL rx_first_latency got=%0h/%h exp=1/0211", rx_valid, rd_data); end
    D_push = 16'h0322; step();
    D_push = 16'hFF33; step();
    push = 1'b0; rd_en = 1'b1;
    step();
    checks++; if (rd_data !== 16'hFF33) begin failures++; $display("FAIL rx_broadcast got=%h exp=ff33", rd_data); end
    step();
    checks++; if (rx_valid !== 1'b0 || rd_data !== 16'h0) begin failures++; $display("FAIL rx_drained got=%0h/%h exp=0/0000", rx_valid, rd_data); end
    step(); // rd_en on empty must be ignored
    rd_en = 1'b0; push = 1'b1; D_push = 16'h0244;
    step();
    push = 1'b0;
    checks++; if (rd_data !== 16'h0244 || rx_drop_cnt !== 8'd0) begin failures++; $display("FAIL rx_empty_rd_ignored got=%h/%0d exp=0244/0", rd_data, rx_drop_cnt); end
    rd_en = 1'b1; step(); rd_en = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rx_empty_again got=%0h exp=0", rx_valid); end
  endtask

  task automatic test_rx_drop();
    push = 1'b1;
    for (int k = 0; k < 8; k++) begin
      D_push = 16'h0200 + 16'(k); step();
    end
    checks++; if (rx_drop_cnt !== 8'd0 || rd_data !== 16'h0200) begin failures++; $display("FAIL rx_fill got=%0d/%h exp=0/0200", rx_drop_cnt, rd_data); end
    for (int k = 0; k < 3; k++) begin
      D_push = 16'h02E0 + 16'(k); step();
    end
    checks++; if (rx_drop_cnt !== 8'd3) begin failures++; $display("FAIL rx_drop_three got=%0d exp=3", rx_drop_cnt); end
    D_push = 16'h0377; step(); // non-matching while full: no count
    checks++; if (rx_drop_cnt !== 8'd3) begin failures++; $display("FAIL rx_nomatch_full got=%0d exp=3", rx_drop_cnt); end
    D_push = 16'h02AA; rd_en = 1'b1; step();
    rd_en = 1'b0;
    checks++; if (rx_drop_cnt !== 8'd3 || rd_data !== 16'h0201) begin failures++; $display("FAIL rx_full_push_rd got=%0d/%h exp=3/0201", rx_drop_cnt, rd_data); end
    D_push = 16'h0299;
    for (int k = 0; k < 300; k++) step();
    push = 1'b0;
    checks++; if (rx_drop_cnt !== 8'd255) begin failures++; $display("FAIL rx_drop_sat got=%0d exp=255", rx_drop_cnt); end
    rd_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      logic [15:0] exp_v;
      exp_v = (k < 8) ? 16'h0200 + 16'(k) : 16'h02AA;
      checks++; if (rd_data !== exp_v) begin failures++; $display("FAIL rx_drain_%0d got=%h exp=%h", k, rd_data, exp_v); end
      step();
    end
    rd_en = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rx_drain_end got=%0h exp=0", rx_valid); end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 5; k++) begin
      wr_en = 1'b1; wr_data = 16'h0C00 + 16'(k);
      push = (k < 3); D_push = 16'hFF00 + 16'(k);
      step();
    end
    wr_en = 1'b0; push = 1'b0;
    checks++; if (D_pop !== 16'h0C00 || rd_data !== 16'hFF00) begin failures++; $display("FAIL both_loaded got=%h/%h exp=0c00/ff00", D_pop, rd_data); end
    checks++; if (tx_ovf_cnt !== 8'd2 || rx_drop_cnt !== 8'd255) begin failures++; $display("FAIL pre_reset_counters got=%0d/%0d exp=2/255", tx_ovf_cnt, rx_drop_cnt); end
    reset = 1'b1; wr_en = 1'b1; pop = 1'b1; push = 1'b1; rd_en = 1'b1;
    wr_data = 16'h0D0D; D_push = 16'h0202;
    step();
    reset = 1'b0; wr_en = 1'b0; pop = 1'b0; push = 1'b0; rd_en = 1'b0;
    checks++; if (pndng !== 1'b0 || rx_valid !== 1'b0 || tx_full !== 1'b0) begin failures++; $display("FAIL mid_reset_flags got=%0h/%0h/%0h exp=0/0/0", pndng, rx_valid, tx_full); end
    checks++; if (D_pop !== 16'h0 || rd_data !== 16'h0) begin failures++; $display("FAIL mid_reset_data got=%h/%h exp=0000/0000", D_pop, rd_data); end
    checks++; if (tx_ovf_cnt !== 8'd0 || rx_drop_cnt !== 8'd0) begin failures++; $display("FAIL mid_reset_counters got=%0d/%0d exp=0/0", tx_ovf_cnt, rx_drop_cnt); end
    step();
    checks++; if (pndng !== 1'b0 || rx_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_ops_ignored got=%0h/%0h exp=0/0", pndng, rx_valid); end
    wr_en = 1'b1; wr_data = 16'h7777; push = 1'b1; D_push = 16'h0288;
    step();
    wr_en = 1'b0; push = 1'b0;
    checks++; if (D_pop !== 16'h7777 || rd_data !== 16'h0288) begin failures++; $display("FAIL post_reset_use got=%h/%h exp=7777/0288", D_pop, rd_data); end
  endtask

  initial begin
    test_reset();
    test_tx_order();
    test_tx_overflow();
    test_wrap();
    test_rx_filter();
    test_rx_drop();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
